hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of event counters.
REQ-002 SHALL have parameter TIMEOUT, default 256, consecutive memory-wait cycles before mem_timeout sets.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port id_rs  input  5  rs field of instruction in ID.
REQ-006 SHALL have port id_rt  input  5  rt field of instruction in ID.
REQ-007 SHALL have port id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-008 SHALL have port idex_rt  input  5  rt held in ID/EX stage.
REQ-009 SHALL have port idex_memread  input  1  MemRead bit held in ID/EX stage.
REQ-010 SHALL have port exmem_memreq  input  1  MEM stage issuing a data-memory read or write.
REQ-011 SHALL have port dmem_ready  input  1  data memory completes the request this cycle.
REQ-012 SHALL have port ex_branch_taken  input  1  branch resolved taken in EX.
REQ-013 SHALL have port pc_write  output  1  PC update enable.
REQ-014 SHALL have port ifid_write  output  1  IF/ID load enable.
REQ-015 SHALL have port ifid_flush  output  1  IF/ID cleared to NOP on next edge.
REQ-016 SHALL have port idex_bubble  output  1  zero the EX/MEM/WB control fields loaded into ID/EX.
REQ-017 SHALL have port freeze  output  1  hold ID/EX and EX/MEM contents.
REQ-018 SHALL have port state  output  2  registered FSM state.
REQ-019 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.
REQ-020 SHALL have port mem_timeout  output  1  sticky memory-wait timeout flag.

Function
REQ-021 SHALL compute mem_wait = exmem_memreq AND NOT dmem_ready.
REQ-022 SHALL compute load_use = idex_memread AND idex_rt != 0 AND (idex_rt == id_rs OR (id_uses_rt AND idex_rt == id_rt)).
REQ-023 SHALL resolve same-cycle priority: mem_wait > ex_branch_taken > load_use > normal.
REQ-024 SHALL on mem_wait drive freeze=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0.
REQ-025 SHALL on branch (no mem_wait) drive pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, freeze=0.
REQ-026 SHALL on load_use (neither above) drive pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, freeze=0.
REQ-027 SHALL in normal case drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, freeze=0.
REQ-028 SHALL derive control outputs combinationally in the same cycle as the inputs.
REQ-029 SHALL register state each edge as the action taken that cycle: RUN=0, MEM_WAIT=1, LU_STALL=2, FLUSH=3.
REQ-030 SHALL suppress load_use when state==LU_STALL (at most one consecutive load-use bubble); mem_wait and branch are never suppressed.
REQ-031 SHALL increment stall_cnt by 1 on each edge where mem_wait or an unsuppressed load_use action was taken, saturating at all-ones.
REQ-032 SHALL increment flush_cnt by 1 on each edge where the branch action was taken, saturating at all-ones.
REQ-033 SHALL count consecutive MEM_WAIT cycles internally, clearing on any non-mem_wait cycle; mem_timeout SHALL set on the edge where the count reaches TIMEOUT and stay set until reset.
REQ-034 SHALL keep counting and flagging unaffected by mem_timeout (flag is status only).

Reset
REQ-035 SHALL on rst=1 immediately (no clock) force state=RUN, stall_cnt=0, flush_cnt=0, mem_timeout=0, wait counter=0.
REQ-036 SHALL while rst=1 drive pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, freeze=0, regardless of other inputs.
REQ-037 SHALL resume REQ-023 priority on the first edge after rst deasserts, starting from RUN.

Verification
REQ-038 SHALL cover load-use: idex_memread=1, idex_rt=5, id_rs=5 -> one cycle pc_write=0, idex_bubble=1, state=2, stall_cnt=1; next cycle with same inputs -> normal outputs.
REQ-039 SHALL cover $zero: idex_memread=1, idex_rt=0, id_rs=0 -> no stall, stall_cnt unchanged.
REQ-040 SHALL cover simultaneous branch and load_use -> ifid_flush=1, idex_bubble=1, pc_write=1, flush_cnt+1, stall_cnt unchanged, state=3.
REQ-041 SHALL cover mem wait: exmem_memreq=1, dmem_ready=0 for 3 cycles with ex_branch_taken=1 -> freeze=1 each cycle, stall_cnt=3, flush_cnt=0.
REQ-042 SHALL cover timeout: TIMEOUT=4, 4 wait cycles -> mem_timeout=1 after 4th edge; remains 1 after dmem_ready=1; clears only on rst.
REQ-043 SHALL cover saturation and async reset: CNT_W=2, 5 stalls -> stall_cnt=3; rst asserted mid-cycle -> counters 0 before next edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard controller that arbitrates memory waits, taken
//             branches and load-use stalls, with event counters and a timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       idex_rt,
  input  logic             idex_memread,
  input  logic             exmem_memreq,
  input  logic             dmem_ready,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    LU_STALL = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              mem_wait;
  logic              load_use;

  assign mem_wait = exmem_memreq & ~dmem_ready;
  // A second consecutive load-use bubble is never needed: the load has moved on.
  assign load_use = idex_memread && (idex_rt != 5'd0) && (state_q != LU_STALL) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
  assign wait_nxt = wait_cnt + WAIT_W'(1);
  assign state    = state_q;

  always_comb begin
    state_d     = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_wait) begin
      state_d    = MEM_WAIT;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      freeze     = 1'b1;
    end else if (ex_branch_taken) begin
      state_d     = FLUSH;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      state_d     = LU_STALL;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (((state_d == MEM_WAIT) || (state_d == LU_STALL)) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state_d == FLUSH) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      // Wait run length saturates at the limit so long waits never wrap.
      if (state_d == MEM_WAIT) begin
        if (wait_cnt != WAIT_LIM)
          wait_cnt <= wait_nxt;
        if (wait_nxt == WAIT_LIM)
          mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Directed self-checking bench for hazard_ctrl (default and small
//             CNT_W/TIMEOUT instances driven in parallel).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] idex_rt;
  logic       idex_memread;
  logic       exmem_memreq;
  logic       dmem_ready;
  logic       ex_branch_taken;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, freeze, mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_freeze, s_mem_timeout;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_rt(idex_rt), .idex_memread(idex_memread), .exmem_memreq(exmem_memreq),
    .dmem_ready(dmem_ready), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .freeze(freeze), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  hazard_ctrl #(.CNT_W(2), .TIMEOUT(4)) dut_s (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_rt(idex_rt), .idex_memread(idex_memread), .exmem_memreq(exmem_memreq),
    .dmem_ready(dmem_ready), .ex_branch_taken(ex_branch_taken),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .freeze(s_freeze), .state(s_state),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .mem_timeout(s_mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic pc, input logic ifw, input logic fl,
                     input logic bub, input logic frz);
    check({tag, ".pc_write"},    pc_write,    pc);
    check({tag, ".ifid_write"},  ifid_write,  ifw);
    check({tag, ".ifid_flush"},  ifid_flush,  fl);
    check({tag, ".idex_bubble"}, idex_bubble, bub);
    check({tag, ".freeze"},      freeze,      frz);
  endtask

  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic mreq,
                       input logic rdy, input logic br);
    idex_memread    = mr;
    idex_rt         = ex_rt;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = urt;
    exmem_memreq    = mreq;
    dmem_ready      = rdy;
    ex_branch_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    ctl("rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("rst.state", state, 0);
    check("rst.stall", stall_cnt, 0);
    check("rst.flush", flush_cnt, 0);
    check("rst.timeout", mem_timeout, 0);
    tick();
    check("rst_edge.state", state, 0);
    check("rst_edge.stall", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // load-use on rs: one bubble, then suppressed
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 ctl("lu1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("lu1.state", state, 2);
    check("lu1.stall", stall_cnt, 1);
    check("lu1.s_stall", s_stall_cnt, 1);
    ctl("lu1_again", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("lu1_again.state", state, 0);
    check("lu1_again.stall", stall_cnt, 1);

    // rt match without id_uses_rt: no hazard
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 ctl("rt_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("rt_unused.stall", stall_cnt, 1);

    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 ctl("rt_used", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("rt_used.state", state, 2);
    check("rt_used.stall", stall_cnt, 2);

    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle.state", state, 0);

    // $zero never stalls
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 ctl("zero", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("zero.state", state, 0);
    check("zero.stall", stall_cnt, 2);

    // branch beats load-use
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 ctl("br_lu", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("br_lu.state", state, 3);
    check("br_lu.flush", flush_cnt, 1);
    check("br_lu.stall", stall_cnt, 2);

    // asynchronous reset mid-cycle
    rst = 1'b1;
    #1;
    check("arst1.state", state, 0);
    check("arst1.stall", stall_cnt, 0);
    check("arst1.flush", flush_cnt, 0);
    check("arst1.s_stall", s_stall_cnt, 0);
    ctl("arst1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // memory wait beats branch
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 ctl("mw_br", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("mw_br.state", state, 1);
    end
    check("mw_br.stall", stall_cnt, 3);
    check("mw_br.flush", flush_cnt, 0);
    check("mw_br.s_stall", s_stall_cnt, 3);
    check("mw_br.s_timeout", s_mem_timeout, 0);

    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1 ctl("ready", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("ready.state", state, 0);

    // wait run restarts after the ready cycle
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("mw2.freeze", freeze, 1);
      tick();
    end
    check("mw2.s_timeout", s_mem_timeout, 0);
    check("mw2.stall", stall_cnt, 6);
    check("mw2.s_stall_sat", s_stall_cnt, 3);
    tick();
    check("mw3.s_timeout", s_mem_timeout, 1);
    check("mw3.timeout", mem_timeout, 0);
    check("mw3.stall", stall_cnt, 7);
    check("mw3.s_stall_sat", s_stall_cnt, 3);

    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1 ctl("ready2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("ready2.s_timeout", s_mem_timeout, 1);
    check("ready2.state", state, 0);

    rst = 1'b1;
    #1;
    check("arst2.s_timeout", s_mem_timeout, 0);
    check("arst2.s_stall", s_stall_cnt, 0);
    check("arst2.stall", stall_cnt, 0);
    check("arst2.state", state, 0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
